// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches from a synchronous instruction memory and
// offers each instruction to the control unit with a valid/ready handshake.
module instr_sequencer #(
  parameter int         PC_W    = 4,
  parameter logic [2:0] HALT_OP = 3'b111
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            step,
  input  logic            restart,
  output logic            imem_rd,
  output logic [PC_W-1:0] imem_addr,
  input  logic [11:0]     imem_data,
  output logic [11:0]     instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PC_W-1:0] r_pc;
  logic [11:0]     r_instr;
  logic            w_accept;
  logic            w_is_halt;

  assign w_accept  = (r_state == S_ISSUE) && instr_ready;
  assign w_is_halt = (imem_data[11:9] == HALT_OP);

  always_comb begin
    w_next = r_state;
    if (restart) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (run || step) w_next = S_FETCH;
        S_FETCH: w_next = S_WAIT;
        S_WAIT:  w_next = w_is_halt ? S_HALT : S_ISSUE;
        S_ISSUE: if (w_accept) w_next = run ? S_FETCH : S_IDLE;
        S_HALT:  w_next = S_HALT;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_instr <= 12'h000;
    end else begin
      r_state <= w_next;
      if (restart) begin
        r_pc <= '0;
      end else begin
        if (w_accept) r_pc <= r_pc + PC_W'(1);
        if (r_state == S_WAIT) r_instr <= imem_data;
      end
    end
  end

  // All handshake/status outputs decode the registered state only
  assign imem_rd     = (r_state == S_FETCH);
  assign instr_valid = (r_state == S_ISSUE);
  assign busy        = (r_state == S_FETCH) ||
                       (r_state == S_WAIT)  ||
                       (r_state == S_ISSUE);
  assign halted      = (r_state == S_HALT);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;

endmodule
